timer_alarm_ctrl: RTL and testbench



---
 rtl/timer_alarm_ctrl_pkg.sv | 8 +
 rtl/timer_alarm_ctrl_if.sv | 23 ++
 rtl/timer_alarm_ctrl_zero_edge_detect.sv | 19 +
 rtl/timer_alarm_ctrl.sv | 97 +++++++++
 tb/tb_timer_alarm_ctrl.sv | 135 +++++++++++++
 5 files changed

// File: rtl/timer_alarm_ctrl_pkg.sv
// timer_alarm_pkg: shared FSM state type and default parameters for timer_alarm_ctrl
//   Contents: state_e (IDLE, ARMED, ALARM), Q_W_DEF, CNT_W_DEF, TIMEOUT_DEF
package timer_alarm_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_e;
    localparam int Q_W_DEF     = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/timer_alarm_ctrl_if.sv
// timer_alarm_ctrl_if: timer count / control inputs and alarm status outputs
//   master: drives q, enable, ack, clr_cnt; observes expire, alarm, missed, expire_count, timeout_flag
//   slave : the alarm controller side (directions reversed)
interface timer_alarm_ctrl_if
    import timer_alarm_pkg::*;
#(
    parameter int Q_W   = Q_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [Q_W-1:0]   q;
    logic             enable;
    logic             ack;
    logic             clr_cnt;
    logic             expire;
    logic             alarm;
    logic             missed;
    logic [CNT_W-1:0] expire_count;
    logic             timeout_flag;
    modport master (output q, enable, ack, clr_cnt,
                    input  expire, alarm, missed, expire_count, timeout_flag);
    modport slave  (input  q, enable, ack, clr_cnt,
                    output expire, alarm, missed, expire_count, timeout_flag);
endinterface

// File: rtl/timer_alarm_ctrl_zero_edge_detect.sv
// zero_edge_detect: single-cycle pulse when the timer count arrives at zero
//   Ports: clk, rst_n (sync, active-low), q_i (count value), zero_rise_o (arrival pulse)
//   zero_q resets to 1 so a count already sitting at zero never fires after reset.
module zero_edge_detect #(
    parameter int Q_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [Q_W-1:0] q_i,
    output logic           zero_rise_o
);
    logic zero, zero_q;
    assign zero = (q_i == '0);
    always_ff @(posedge clk) begin
        if (!rst_n) zero_q <= 1'b1;
        else        zero_q <= zero;
    end
    assign zero_rise_o = zero & ~zero_q;
endmodule

// File: rtl/timer_alarm_ctrl.sv
// timer_alarm_ctrl: expiry detector with sticky alarm, missed flag and saturating expiry counter
//   Ports: clk, rst_n (sync, active-low), bus (timer_alarm_ctrl_if.slave)
//   Optional: define TIMER_ALARM_TIMEOUT_EN to auto-clear an unacknowledged alarm after
//   TIMEOUT cycles and raise the sticky timeout_flag; otherwise timeout_flag is tied to 0.
module timer_alarm_ctrl
    import timer_alarm_pkg::*;
#(
    parameter int Q_W     = Q_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                clk,
    input logic                rst_n,
    timer_alarm_ctrl_if.slave  bus
);
    state_e           state_q;
    logic             expire_q, alarm_q, missed_q;
    logic [CNT_W-1:0] cnt_q;
    logic             zero_rise, in_alarm, hit, miss, timeout;

    zero_edge_detect #(.Q_W(Q_W)) u_zero (
        .clk         (clk),
        .rst_n       (rst_n),
        .q_i         (bus.q),
        .zero_rise_o (zero_rise)
    );

    assign in_alarm = (state_q == ALARM);
    // accepted expiry: armed or alarming, and still enabled
    assign hit      = bus.enable & zero_rise & (state_q != IDLE);
    // expiry while the previous one is still unacknowledged
    assign miss     = hit & in_alarm & ~bus.ack;

`ifdef TIMER_ALARM_TIMEOUT_EN
    logic [15:0] wait_q;
    logic        tflag_q;
    // a new expiry restarts the wait, so it also suppresses the timeout that cycle
    assign timeout = in_alarm & bus.enable & ~bus.ack & ~zero_rise & (wait_q == 16'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            wait_q  <= (in_alarm && !zero_rise) ? wait_q + 16'd1 : '0;
            tflag_q <= bus.clr_cnt ? 1'b0 : (tflag_q | timeout);
        end
    end
    assign bus.timeout_flag = tflag_q;
`else
    logic unused_timeout;
    assign unused_timeout   = (TIMEOUT < 1);
    assign timeout          = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alarm_q  <= 1'b0;
            expire_q <= 1'b0;
            missed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            expire_q <= hit;
            missed_q <= bus.clr_cnt ? 1'b0 : (missed_q | miss);
            cnt_q    <= bus.clr_cnt ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
            case (state_q)
                IDLE:  if (bus.enable) state_q <= ARMED;
                ARMED: begin
                    if (!bus.enable) state_q <= IDLE;
                    else if (zero_rise) begin
                        state_q <= ALARM;
                        alarm_q <= 1'b1;
                    end
                end
                ALARM: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;
                        alarm_q <= 1'b0;
                    end else if ((bus.ack && !zero_rise) || timeout) begin
                        state_q <= ARMED;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.expire       = expire_q;
    assign bus.alarm        = alarm_q;
    assign bus.missed       = missed_q;
    assign bus.expire_count = cnt_q;
endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// tb_timer_alarm_ctrl: directed self-checking bench for timer_alarm_ctrl
module tb_timer_alarm_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    timer_alarm_ctrl_if #(.Q_W(4), .CNT_W(8)) bus ();

    timer_alarm_ctrl #(.Q_W(4), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic e, input logic a, input logic m,
                             input logic [7:0] c);
        check({tag, ".expire"}, 32'(bus.expire), 32'(e));
        check({tag, ".alarm"},  32'(bus.alarm),  32'(a));
        check({tag, ".missed"}, 32'(bus.missed), 32'(m));
        check({tag, ".count"},  32'(bus.expire_count), 32'(c));
    endtask

    initial begin
        rst_n = 1'b0; bus.q = 4'd3; bus.enable = 1'b0; bus.ack = 1'b0; bus.clr_cnt = 1'b0;
        tick(); tick();
        check_out("reset", 0, 0, 0, 0);
        check("reset.tflag", 32'(bus.timeout_flag), 0);

        // countdown 3,2,1,0: expire and alarm in the cycle after q=0
        rst_n = 1'b1; bus.enable = 1'b1; bus.q = 4'd3; tick();
        bus.q = 4'd2; tick();
        bus.q = 4'd1; tick();
        check_out("countdown", 0, 0, 0, 0);
        bus.q = 4'd0; tick();
        check_out("expiry1", 1, 1, 0, 1);

        // held at zero: no re-fire
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold.expire", 32'(bus.expire), 0);
        end
        check_out("hold", 0, 1, 0, 1);

        // second expiry while pending -> missed
        bus.q = 4'd5; tick();
        bus.q = 4'd0; tick();
        check_out("missed", 1, 1, 1, 2);
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0;
        check_out("ack", 0, 0, 1, 2);

        // ack in ARMED ignored: expiry still raises alarm
        bus.q = 4'd4; bus.ack = 1'b1; tick();
        bus.q = 4'd0; tick();
        bus.ack = 1'b0;
        check_out("ack_armed", 1, 1, 1, 3);

        // saturation: 257 more expiries -> 260 total
        for (int i = 0; i < 257; i++) begin
            bus.q = 4'd1; tick();
            bus.q = 4'd0; tick();
        end
        check_out("saturate", 1, 1, 1, 255);

        // clear coincident with an expiry (and a missed set): clear wins
        bus.q = 4'd1; tick();
        bus.q = 4'd0; bus.clr_cnt = 1'b1; tick();
        bus.clr_cnt = 1'b0;
        check_out("clr_coinc", 1, 1, 0, 0);

        // ack together with new expiry: stay in ALARM, missed not set
        bus.q = 4'd1; tick();
        bus.q = 4'd0; bus.ack = 1'b1; tick();
        bus.ack = 1'b0;
        check_out("ack_rise", 1, 1, 0, 1);

        // reset in ALARM with q=0, then no fire until q leaves and returns
        rst_n = 1'b0; tick();
        check_out("rst_alarm", 0, 0, 0, 0);
        rst_n = 1'b1; tick(); tick(); tick();
        check_out("post_rst", 0, 0, 0, 0);
        bus.q = 4'd2; tick();
        bus.q = 4'd0; tick();
        check_out("post_rst_exp", 1, 1, 0, 1);

        // disable in ALARM drops alarm; re-enable with q held at 0 stays quiet
        bus.enable = 1'b0; tick();
        check_out("disable", 0, 0, 0, 1);
        bus.enable = 1'b1; tick(); tick();
        check_out("reenable", 0, 0, 0, 1);
        check("default.tflag", 32'(bus.timeout_flag), 0);

`ifdef TIMER_ALARM_TIMEOUT_EN
        bus.q = 4'd1; tick();
        bus.q = 4'd0; tick();
        check("to.entry", 32'(bus.alarm), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to.hold", 32'(bus.alarm), 1);
        end
        tick();
        check("to.drop", 32'(bus.alarm), 0);
        check("to.flag", 32'(bus.timeout_flag), 1);
        bus.clr_cnt = 1'b1; tick();
        bus.clr_cnt = 1'b0;
        check("to.clr", 32'(bus.timeout_flag), 0);
        bus.q = 4'd1; tick();
        bus.q = 4'd0; tick();
        for (int i = 1; i < 16; i++) tick();
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0;
        check("to.ack_alarm", 32'(bus.alarm), 0);
        check("to.ack_flag", 32'(bus.timeout_flag), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
